// File: rtl/lcd_stream_out.sv
// RGB565 pixel stream to parallel LCD timing, with input FIFO and SOF-locked frame alignment.
// Optional colour-bar idle pattern: define LCD_STREAM_OUT_TESTPAT_EN.
module lcd_stream_out #(
    parameter int H_ACTIVE   = 480,
    parameter int H_BLANK    = 80,
    parameter int V_ACTIVE   = 272,
    parameter int V_BLANK    = 29,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sof,
    input  logic [15:0] s_data,
    output logic        LCD_DE,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [1:0] {SEEK, ARMED, RUN} state_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          first;

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head_sof;
    logic [15:0]   head_data;

    state_t        state;
    state_t        state_nxt;
    logic          pix_en;
    logic          uf_set;
    logic          blank_set;
    logic [15:0]   pix_nxt;

`ifdef LCD_STREAM_OUT_TESTPAT_EN
    logic          blank_frame;

    function automatic logic [15:0] bar_colour(input logic [HW-1:0] h);
        int idx;
        idx = int'(h) / (H_ACTIVE / 8);
        case (idx)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction
`endif

    // Free-running raster timing
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign first  = (h_cnt == '0) && (v_cnt == '0);

    // Input FIFO; ready is held low until the first clock out of reset
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign s_ready   = ready_en && !full;
    assign push      = s_valid && s_ready;
    assign head_sof  = mem[rd_ptr][16];
    assign head_data = mem[rd_ptr][15:0];

    always_ff @(posedge PixelClk) begin
        if (push)
            mem[wr_ptr] <= {s_sof, s_data};
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame alignment FSM
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST)
            state <= SEEK;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        pix_en    = 1'b0;
        uf_set    = 1'b0;
        blank_set = 1'b0;
        case (state)
            SEEK: begin
                if (!empty) begin
                    if (head_sof)
                        state_nxt = ARMED;
                    else
                        pop = 1'b1;
                end
            end
            ARMED: begin
                if (first && !empty) begin
                    pop       = 1'b1;
                    pix_en    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (active) begin
                    if (empty) begin
                        uf_set    = 1'b1;
                        blank_set = 1'b1;
                        state_nxt = SEEK;
                    end else if (head_sof && !first) begin
                        blank_set = 1'b1;
                        state_nxt = ARMED;
                    end else if (!head_sof && first) begin
                        // Lost frame lock at the origin: resynchronise via SEEK
                        state_nxt = SEEK;
                    end else begin
                        pop    = 1'b1;
                        pix_en = 1'b1;
                    end
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

`ifdef LCD_STREAM_OUT_TESTPAT_EN
    // After an underflow or early SOF the rest of the frame stays black, not bars
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST)
            blank_frame <= 1'b0;
        else if (first)
            blank_frame <= blank_set;
        else if (blank_set)
            blank_frame <= 1'b1;
    end

    always_comb begin
        pix_nxt = 16'h0000;
        if (pix_en)
            pix_nxt = head_data;
        else if (active && (state != RUN) && !(blank_frame && !first))
            pix_nxt = bar_colour(h_cnt);
    end
`else
    always_comb begin
        pix_nxt = 16'h0000;
        if (pix_en)
            pix_nxt = head_data;
    end
`endif

    // Output register: DE and colour share one cycle of latency
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            LCD_DE    <= 1'b0;
            LCD_R     <= '0;
            LCD_G     <= '0;
            LCD_B     <= '0;
            underflow <= 1'b0;
        end else begin
            LCD_DE                <= active;
            {LCD_R, LCD_G, LCD_B} <= pix_nxt;
            if (uf_set)
                underflow <= 1'b1;
        end
    end

endmodule
